// File: rtl/csa_pipe.sv
// csa_pipe: two-stage pipelined carry-select adder/subtractor with valid/ready flow control
//   Stage 1 precomputes every BLK-bit block for carry-in 0 and 1; stage 2 resolves
//   the block carry chain through select muxes and registers the result.
//   Optional build macro CSA_SAT_EN: signed-saturate sum on overflow (flags stay raw).
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid, in_ready       operand handshake (in_ready combinational from out_ready)
//   a, b, cin, sub           operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid, out_ready     result handshake
//   sum, cout, second_out    result, carry out of MSB, carry into MSB
//   ovf                      signed overflow, cout ^ second_out
module csa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             second_out,
  output logic             ovf
);
  localparam int NB = WIDTH / BLK;
  // Ripple one block; returns {carry into block MSB, carry out, sum}.
  function automatic logic [BLK+1:0] blk_add(input logic [BLK-1:0] x, input logic [BLK-1:0] y, input logic ci);
    logic c, cm;
    logic [BLK-1:0] s;
    c = ci;
    cm = ci;
    s = '0;
    for (int i = 0; i < BLK; i++) begin
      cm = c;
      s[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {cm, c, s};
  endfunction
  logic             s1_valid, s1_adv, s2_adv, acc;
  logic [WIDTH-1:0] bb;
  logic             c0;
  logic [BLK+1:0]   x0, x1;
  logic [BLK:0]     n0 [NB];
  logic [BLK:0]     n1 [NB];
  logic [BLK:0]     r0 [NB];
  logic [BLK:0]     r1 [NB];
  logic             nm0, nm1, m0, m1;
  logic [BLK:0]     sel;
  logic             cy;
  logic [WIDTH-1:0] sum_n, res;
  logic             cout_n, sec_n, ovf_n;
  assign s2_adv   = out_ready | ~out_valid;
  assign s1_adv   = s1_valid & s2_adv;
  assign in_ready = ~s1_valid | s1_adv;
  assign acc      = in_valid & in_ready;
  // Stage 1: block 0 only ever sees the true carry-in c0, so both of its slots hold that result.
  always_comb begin
    bb = sub ? ~b : b;
    c0 = sub | cin;
    x0 = '0;
    x1 = '0;
    nm0 = 1'b0;
    nm1 = 1'b0;
    for (int k = 0; k < NB; k++) begin
      x0 = blk_add(a[k*BLK +: BLK], bb[k*BLK +: BLK], k == 0 ? c0 : 1'b0);
      x1 = blk_add(a[k*BLK +: BLK], bb[k*BLK +: BLK], k == 0 ? c0 : 1'b1);
      n0[k] = x0[BLK:0];
      n1[k] = x1[BLK:0];
      if (k == NB - 1) begin
        nm0 = x0[BLK+1];
        nm1 = x1[BLK+1];
      end
    end
  end
`ifdef CSA_SAT_EN
  logic a_msb;
  always_ff @(posedge clk)
    if (acc) a_msb <= a[WIDTH-1];
`endif
  always_ff @(posedge clk)
    if (acc) begin
      r0 <= n0;
      r1 <= n1;
      m0 <= nm0;
      m1 <= nm1;
    end
  // Stage 2: carry chain of select muxes; second_out comes from the MSB block's selected path.
  always_comb begin
    cy = 1'b0;
    sel = '0;
    sum_n = '0;
    sec_n = 1'b0;
    for (int k = 0; k < NB; k++) begin
      sel = cy ? r1[k] : r0[k];
      sum_n[k*BLK +: BLK] = sel[BLK-1:0];
      if (k == NB - 1) sec_n = cy ? m1 : m0;
      cy = sel[BLK];
    end
    cout_n = cy;
    ovf_n = cout_n ^ sec_n;
  end
`ifdef CSA_SAT_EN
  // On overflow the true result lies beyond the limit on the side of a's sign.
  assign res = ovf_n ? {a_msb, {(WIDTH-1){~a_msb}}} : sum_n;
`else
  assign res = sum_n;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      second_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      s1_valid <= acc | (s1_valid & ~s1_adv);
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum        <= res;
          cout       <= cout_n;
          second_out <= sec_n;
          ovf        <= ovf_n;
        end
      end
    end
endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: scoreboard bench for csa_pipe against an arithmetic reference model
module tb_csa_pipe;
  localparam int W = 16;
  localparam int B = 4;
  typedef logic [W+2:0] exp_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, second_out, ovf;
  logic [W-1:0] a, b, sum;
  exp_t q[$];
  exp_t held;
  logic hold = 1'b0;
  int checks = 0, errors = 0, n_out = 0;
  always #5 clk = ~clk;
  csa_pipe #(.WIDTH(W), .BLK(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .second_out(second_out), .ovf(ovf)
  );
  // Reference: plain wide addition; carry into MSB recovered from the MSB sum bit.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input logic s);
    logic [W-1:0] bx, r;
    logic [W:0] full;
    logic co, sec, ov;
    bx = s ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bx} + {{W{1'b0}}, s | c};
    r = full[W-1:0];
    co = full[W];
    sec = r[W-1] ^ av[W-1] ^ bx[W-1];
    ov = (av[W-1] == bx[W-1]) && (r[W-1] != av[W-1]);
`ifdef CSA_SAT_EN
    if (ov) r = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {r, co, sec, ov};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  // Monitor: pops the scoreboard on every taken result and checks stalled outputs hold still.
  always @(negedge clk) begin
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'({sum, cout, second_out, ovf}), 64'(held));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", {sum, cout, second_out, ovf});
        end else chk("result", 64'({sum, cout, second_out, ovf}), 64'(q.pop_front()));
        hold = 1'b0;
      end else if (out_valid) begin
        hold = 1'b1;
        held = {sum, cout, second_out, ovf};
      end else hold = 1'b0;
    end
  end
  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input logic s, output logic acc);
    in_valid = v;
    a = av;
    b = bv;
    cin = c;
    sub = s;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) q.push_back(model(av, bv, c, s));
    @(posedge clk);
    #1;
  endtask
  task automatic drain(output int t);
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    logic acc;
    int cnt, base, t;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({cout, second_out, ovf}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("latency_cycle2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, acc);
    drive(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, acc);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
    drive(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);
    drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
    in_valid = 1'b0;
    drain(t);
    out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
      cnt += int'(acc);
    end
    chk("bp_accepted", 64'(cnt), 64'd2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release1", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain(t);
    out_ready = 1'b0;
    drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, acc);
    drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, acc);
    chk("mid_rst_inflight", 64'(q.size()), 64'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(sum), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    base = n_out;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
      cnt += int'(acc);
    end
    in_valid = 1'b0;
    drain(t);
    chk("tp_accepted", 64'(cnt), 64'd1000);
    chk("tp_outputs", 64'(n_out - base), 64'd1000);
    chk("tp_tail", 64'(t <= 2), 64'd1);
    for (int i = 0; i < 600; i++) begin
      out_ready = 1'($urandom);
      drive(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    drain(t);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
